// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha1_pkg;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    WAIT,
    TAIL
  } state_t;

  localparam int WORD_W        = 32;
  localparam int BLOCK_W       = 512;
  localparam int WORDS_PER_BLK = 16;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int LEN_WORD_HI   = 14;
  localparam int LEN_WORD_LO   = 15;

endpackage

// File: rtl/sha1_pad_word.sv
// Combinational tail-word formatter: optional byte swap, keeps the first nbytes bytes,
// puts 0x80 right after them and zeroes the rest.
module sha1_pad_word
  import sha1_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [2:0]        nbytes,
  input  logic              swap,
  output logic [WORD_W-1:0] padded
);

  logic [WORD_W-1:0] ordered;

  always_comb begin
    ordered = swap ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;
    padded  = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes) begin
        padded[31-8*b -: 8] = ordered[31-8*b -: 8];
      end else if (3'(b) == nbytes) begin
        padded[31-8*b -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// Streams 32-bit message words into padded 512-bit SHA-1 blocks, one core run per block.
// Define SHA1_PAD_BYTE_SWAP_EN to accept little-endian input words.
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WORD_W-1:0]  IN_DATA,
  input  logic               IN_LAST,
  input  logic [2:0]         IN_BYTES,
  output logic [BLOCK_W-1:0] BLK_OUT,
  output logic               BLK_START,
  output logic               BLK_FIRST,
  output logic               BLK_LAST,
  input  logic               CORE_DONE,
  output logic               BUSY
);

`ifdef SHA1_PAD_BYTE_SWAP_EN
  localparam logic SWAP = 1'b1;
`else
  localparam logic SWAP = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q [WORDS_PER_BLK];
  logic [WORD_W-1:0] buf_d [WORDS_PER_BLK];
  logic [3:0]        idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              first_q, first_d;
  logic              blk_first_q, blk_first_d;
  logic              blk_last_q, blk_last_d;
  logic              tail_q, tail_d;
  logic              pad_tail_q, pad_tail_d;
  logic              busy_q, busy_d;

  logic              hs;
  logic [2:0]        nbytes;
  logic [2:0]        pad_nbytes;
  logic              last_full;
  logic [4:0]        pad_idx;
  logic [LEN_W-1:0]  len_last;
  logic [63:0]       len_last_w;
  logic [63:0]       len_q_w;
  logic [WORD_W-1:0] in_word_padded;

  assign IN_READY   = (state_q == FILL) & nRST;
  assign hs         = IN_VALID & IN_READY;
  assign nbytes     = (IN_BYTES > 3'd4) ? 3'd4 : IN_BYTES;
  // Non-final words pass through untouched by asking for all four bytes.
  assign pad_nbytes = IN_LAST ? nbytes : 3'd4;
  assign last_full  = (nbytes == 3'd4);
  assign pad_idx    = {1'b0, idx_q} + {4'b0, last_full};
  assign len_last   = len_q + LEN_W'({nbytes, 3'b000});
  assign len_last_w = 64'(len_last);
  assign len_q_w    = 64'(len_q);

  sha1_pad_word u_pad_word (
    .word   (IN_DATA),
    .nbytes (pad_nbytes),
    .swap   (SWAP),
    .padded (in_word_padded)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    len_d       = len_q;
    first_d     = first_q;
    blk_first_d = blk_first_q;
    blk_last_d  = blk_last_q;
    tail_d      = tail_q;
    pad_tail_d  = pad_tail_q;
    busy_d      = busy_q;
    unique case (state_q)
      FILL: begin
        if (hs) begin
          busy_d        = 1'b1;
          buf_d[idx_q]  = in_word_padded;
          idx_d         = idx_q + 4'd1;
          if (!IN_LAST) begin
            len_d = len_q + LEN_W'(WORD_W);
            if (idx_q == 4'(WORDS_PER_BLK - 1)) begin
              state_d     = EMIT;
              blk_first_d = first_q;
              blk_last_d  = 1'b0;
              tail_d      = 1'b0;
              pad_tail_d  = 1'b0;
            end
          end else begin
            len_d       = len_last;
            state_d     = EMIT;
            blk_first_d = first_q;
            if (last_full && pad_idx < 5'(WORDS_PER_BLK)) begin
              buf_d[pad_idx[3:0]] = {PAD_BYTE, 24'h0};
            end
            if (pad_idx < 5'(LEN_WORD_HI)) begin
              buf_d[LEN_WORD_HI] = len_last_w[63:32];
              buf_d[LEN_WORD_LO] = len_last_w[31:0];
              blk_last_d = 1'b1;
              tail_d     = 1'b0;
              pad_tail_d = 1'b0;
            end else begin
              // No room for the length here: an extra block carries it.
              blk_last_d = 1'b0;
              tail_d     = 1'b1;
              pad_tail_d = (pad_idx == 5'(WORDS_PER_BLK));
            end
          end
        end
      end
      EMIT: begin
        first_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (CORE_DONE) begin
          if (tail_q) begin
            state_d = TAIL;
          end else begin
            state_d = FILL;
            idx_d   = '0;
            buf_d   = '{default: '0};
            if (blk_last_q) begin
              len_d   = '0;
              first_d = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      TAIL: begin
        buf_d = '{default: '0};
        if (pad_tail_q) begin
          buf_d[0] = {PAD_BYTE, 24'h0};
        end
        buf_d[LEN_WORD_HI] = len_q_w[63:32];
        buf_d[LEN_WORD_LO] = len_q_w[31:0];
        blk_first_d = first_q;
        blk_last_d  = 1'b1;
        tail_d      = 1'b0;
        pad_tail_d  = 1'b0;
        state_d     = EMIT;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= FILL;
      buf_q       <= '{default: '0};
      idx_q       <= '0;
      len_q       <= '0;
      first_q     <= 1'b1;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
      tail_q      <= 1'b0;
      pad_tail_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      first_q     <= first_d;
      blk_first_q <= blk_first_d;
      blk_last_q  <= blk_last_d;
      tail_q      <= tail_d;
      pad_tail_q  <= pad_tail_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    BLK_OUT = '0;
    for (int i = 0; i < WORDS_PER_BLK; i++) begin
      BLK_OUT[BLOCK_W-1-WORD_W*i -: WORD_W] = buf_q[i];
    end
  end

  assign BLK_START = (state_q == EMIT);
  assign BLK_FIRST = blk_first_q & ((state_q == EMIT) | (state_q == WAIT));
  assign BLK_LAST  = blk_last_q & ((state_q == EMIT) | (state_q == WAIT));
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Bench for sha1_msg_padder: byte-level padding model vs. captured blocks, with a core responder.
module tb_sha1_msg_padder;

  logic         CLK;
  logic         nRST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [31:0]  IN_DATA;
  logic         IN_LAST;
  logic [2:0]   IN_BYTES;
  logic [511:0] BLK_OUT;
  logic         BLK_START;
  logic         BLK_FIRST;
  logic         BLK_LAST;
  logic         CORE_DONE;
  logic         BUSY;

  int n_cmp  = 0;
  int n_fail = 0;
  int core_dly = 1;
  bit abort_core = 0;

  logic [511:0] cap_blk[$];
  logic         cap_first[$];
  logic         cap_last[$];
  logic [7:0]   msg[$];
  logic [511:0] exp_blk[$];

  logic [511:0] r_blk;
  logic         r_first, r_last;
  bit           r_abort;

  sha1_msg_padder dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_LAST   (IN_LAST),
    .IN_BYTES  (IN_BYTES),
    .BLK_OUT   (BLK_OUT),
    .BLK_START (BLK_START),
    .BLK_FIRST (BLK_FIRST),
    .BLK_LAST  (BLK_LAST),
    .CORE_DONE (CORE_DONE),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core stand-in: captures each block, holds for core_dly cycles checking stability, then DONE.
  always begin
    @(posedge CLK); #1;
    if (BLK_START === 1'b1 && !abort_core) begin
      r_blk   = BLK_OUT;
      r_first = BLK_FIRST;
      r_last  = BLK_LAST;
      cap_blk.push_back(r_blk);
      cap_first.push_back(r_first);
      cap_last.push_back(r_last);
      r_abort = 0;
      for (int c = 0; c < core_dly; c++) begin
        @(posedge CLK); #1;
        if (abort_core) begin
          r_abort = 1;
          break;
        end
        check("hold_blk_out", BLK_OUT, r_blk);
        check("hold_start", BLK_START, 0);
        check("hold_ready", IN_READY, 0);
        check("hold_last", BLK_LAST, r_last);
        check("hold_first", BLK_FIRST, r_first);
      end
      if (!r_abort) begin
        CORE_DONE = 1'b1;
        @(posedge CLK); #1;
        CORE_DONE = 1'b0;
        if (r_last) begin
          check("done_to_ready", IN_READY, 1);
          check("done_busy_fall", BUSY, 0);
        end
      end
    end
  end

  // FIPS 180-4 padding on a byte stream, then cut into 64-byte blocks.
  task automatic build_expected();
    logic [7:0]   pb[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    pb = msg;
    bits = 64'(msg.size()) * 64'd8;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
    exp_blk.delete();
    for (int b = 0; b < pb.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pb[64*b+j];
      exp_blk.push_back(blk);
    end
  endtask

  function automatic logic [31:0] make_word(input int base, input int nb);
    logic [31:0] w;
    w = $urandom;
    for (int j = 0; j < nb; j++) w[31-8*j -: 8] = msg[base+j];
`ifdef SHA1_PAD_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic send_word(input logic [31:0] data, input logic last, input int nb);
    bit got;
    int c;
    got = 0;
    c = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b1;
    IN_DATA  = data;
    IN_LAST  = last;
    IN_BYTES = last ? 3'(nb) : 3'($urandom_range(0, 7));
    while (!got && c < 400) begin
      got = IN_READY;
      @(posedge CLK); #1;
      c++;
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    check("handshake", got, 1);
    if (got && last) check("last_to_start", BLK_START, 1);
  endtask

  task automatic send_msg(input bit empty_tail);
    int n, full, rem;
    n = msg.size();
    full = n / 4;
    rem = n % 4;
    if (rem != 0) begin
      for (int i = 0; i < full; i++) send_word(make_word(4*i, 4), 1'b0, 4);
      send_word(make_word(4*full, rem), 1'b1, rem);
    end else if (n == 0 || empty_tail) begin
      for (int i = 0; i < full; i++) send_word(make_word(4*i, 4), 1'b0, 4);
      send_word(make_word(0, 0), 1'b1, 0);
    end else begin
      for (int i = 0; i < full - 1; i++) send_word(make_word(4*i, 4), 1'b0, 4);
      send_word(make_word(4*(full-1), 4), 1'b1, 4);
    end
  endtask

  task automatic run_msg(input bit empty_tail);
    int c;
    build_expected();
    cap_blk.delete();
    cap_first.delete();
    cap_last.delete();
    send_msg(empty_tail);
    c = 0;
    while (c < 3000 && !(cap_blk.size() >= exp_blk.size() && BUSY === 1'b0)) begin
      @(posedge CLK); #1;
      c++;
    end
    check("msg_complete", c < 3000, 1);
    check("blk_count", cap_blk.size(), exp_blk.size());
    for (int i = 0; i < exp_blk.size() && i < cap_blk.size(); i++) begin
      check("blk_data", cap_blk[i], exp_blk[i]);
      check("blk_first", cap_first[i], i == 0);
      check("blk_last", cap_last[i], i == exp_blk.size() - 1);
    end
  endtask

  task automatic fill_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    nRST      = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    IN_LAST   = 1'b0;
    IN_BYTES  = '0;
    CORE_DONE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", IN_READY, 0);
    check("rst_start", BLK_START, 0);
    check("rst_first", BLK_FIRST, 0);
    check("rst_last", BLK_LAST, 0);
    check("rst_busy", BUSY, 0);
    check("rst_blk_out", BLK_OUT, 0);
    nRST = 1'b1;
    #1;
    check("post_rst_ready", IN_READY, 1);
    @(posedge CLK); #1;

    // "abc"
    msg = {8'h61, 8'h62, 8'h63};
    run_msg(0);
    check("abc_w0", cap_blk[0][511:480], 32'h61626380);
    check("abc_w15", cap_blk[0][31:0], 32'h00000018);

    // Empty message
    msg.delete();
    run_msg(0);
    check("empty_blk", cap_blk[0], {32'h80000000, 480'h0});

    // Pad-index boundaries: 13, 14, 15, 16
    fill_msg(55);
    run_msg(0);
    fill_msg(56);
    run_msg(0);
    check("b56_w14", cap_blk[0][63:32], 32'h80000000);
    check("b56_blk2_w15", cap_blk[1][31:0], 32'h000001C0);
    fill_msg(56);
    run_msg(1);
    fill_msg(60);
    run_msg(0);
    fill_msg(63);
    run_msg(0);
    fill_msg(64);
    run_msg(0);
    check("b64_blk2_w0", cap_blk[1][511:480], 32'h80000000);
    check("b64_blk2_w15", cap_blk[1][31:0], 32'h00000200);
    fill_msg(64);
    run_msg(1);

    // Slow core: input held off mid-message
    core_dly = 100;
    fill_msg(70);
    run_msg(0);
    core_dly = 1;

    // Reset while waiting on the first of two blocks
    core_dly = 30;
    fill_msg(56);
    cap_blk.delete();
    send_msg(0);
    repeat (3) @(posedge CLK);
    #3;
    abort_core = 1;
    nRST = 1'b0;
    #1;
    check("midrst_start", BLK_START, 0);
    check("midrst_first", BLK_FIRST, 0);
    check("midrst_last", BLK_LAST, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_ready", IN_READY, 0);
    check("midrst_blk_out", BLK_OUT, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    abort_core = 0;
    core_dly = 1;
    msg = {8'h61, 8'h62, 8'h63};
    run_msg(0);
    check("post_rst_abc_w15", cap_blk[0][31:0], 32'h00000018);

    // Random messages
    for (int t = 0; t < 25; t++) begin
      core_dly = $urandom_range(1, 4);
      fill_msg($urandom_range(0, 150));
      run_msg(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
